// File: rtl/hack_pkg.sv
// hack_pkg: FSM state encoding and Hack ALU control words for alu_arbiter
package hack_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [5:0] CTRL_ZERO    = 6'b101010;
    localparam logic [5:0] CTRL_NEG1    = 6'b111010;
    localparam logic [5:0] CTRL_NOTX    = 6'b001101;
    localparam logic [5:0] CTRL_XPLUSY  = 6'b000010;
    localparam logic [5:0] CTRL_XMINUSY = 6'b010011;
endpackage

// File: rtl/Add16.sv
// Add16: 16-bit adder, carry out discarded
module Add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out
);
    assign out = a + b;
endmodule

// File: rtl/And16.sv
// And16: 16-bit bitwise and
module And16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out
);
    assign out = a & b;
endmodule

// File: rtl/Mux16.sv
// Mux16: 16-bit 2:1 mux, sel=1 picks b
module Mux16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] out
);
    assign out = sel ? b : a;
endmodule

// File: rtl/Not16.sv
// Not16: 16-bit bitwise inverter
module Not16 (
    input  logic [15:0] a,
    output logic [15:0] out
);
    assign out = ~a;
endmodule

// File: rtl/hack_alu.sv
// hack_alu: combinational Hack ALU built from the 16-bit gate library
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [5:0]  ctrl,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] x_z, x_zn, x_n, y_z, y_zn, y_n, f_and, f_add, f_o, f_no;
    Mux16 u_zx (.a(x),     .b(16'h0000), .sel(ctrl[5]), .out(x_z));
    Not16 u_nxi (.a(x_z),  .out(x_zn));
    Mux16 u_nx (.a(x_z),   .b(x_zn),     .sel(ctrl[4]), .out(x_n));
    Mux16 u_zy (.a(y),     .b(16'h0000), .sel(ctrl[3]), .out(y_z));
    Not16 u_nyi (.a(y_z),  .out(y_zn));
    Mux16 u_ny (.a(y_z),   .b(y_zn),     .sel(ctrl[2]), .out(y_n));
    And16 u_and (.a(x_n),  .b(y_n),      .out(f_and));
    Add16 u_add (.a(x_n),  .b(y_n),      .out(f_add));
    Mux16 u_f  (.a(f_and), .b(f_add),    .sel(ctrl[1]), .out(f_o));
    Not16 u_noi (.a(f_o),  .out(f_no));
    Mux16 u_no (.a(f_o),   .b(f_no),     .sel(ctrl[0]), .out(out));
    assign zr = ~|out;
    assign ng = out[15];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port arbiter in front of a Hack ALU; ALU_ARBITER_STATS_EN adds per-port grant counters
module alu_arbiter
    import hack_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_x,
    input  logic [15:0] req0_y,
    input  logic [15:0] req1_x,
    input  logic [15:0] req1_y,
    input  logic [5:0]  req0_ctrl,
    input  logic [5:0]  req1_ctrl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_out,
    output logic        rsp_zr,
    output logic        rsp_ng,
    output logic        rsp_id
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0] grant_cnt0,
    output logic [15:0] grant_cnt1
`endif
);
    state_t      state, state_nx;
    logic [15:0] x_r, y_r, alu_out;
    logic [5:0]  ctrl_r;
    logic        id_r, last, gnt1, hs, alu_zr, alu_ng;

    // last == 1 means port 1 was served last, so port 0 wins a tie
    assign gnt1       = req1_valid && (!req0_valid || (FAIR != 0 && !last));
    assign req0_ready = rst_n && state == IDLE && req0_valid && !gnt1;
    assign req1_ready = rst_n && state == IDLE && gnt1;
    assign hs         = req0_ready || req1_ready;
    assign rsp_valid  = state == RESP;
    assign rsp_id     = id_r;

    hack_alu u_alu (.x(x_r), .y(y_r), .ctrl(ctrl_r), .out(alu_out), .zr(alu_zr), .ng(alu_ng));

    // next-state: accept in IDLE, one compute cycle, hold response until taken
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (hs ? EXEC : IDLE) :
                   state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // operand capture, result register and last-served pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= '0;
            y_r     <= '0;
            ctrl_r  <= '0;
            id_r    <= 1'b0;
            rsp_out <= '0;
            rsp_zr  <= 1'b0;
            rsp_ng  <= 1'b0;
            last    <= 1'b1;
        end else begin
            if (hs) begin
                x_r    <= req1_ready ? req1_x : req0_x;
                y_r    <= req1_ready ? req1_y : req0_y;
                ctrl_r <= req1_ready ? req1_ctrl : req0_ctrl;
                id_r   <= req1_ready;
            end
            if (state == EXEC) begin
                rsp_out <= alu_out;
                rsp_zr  <= alu_zr;
                rsp_ng  <= alu_ng;
            end
            if (state == RESP && rsp_ready) last <= id_r;
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    // saturating per-port handshake counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter (round-robin and fixed-priority instances)
module tb_alu_arbiter;
    import hack_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0, rsp_ready = 0;
    logic [15:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0;
    logic [5:0]  req0_ctrl = 0, req1_ctrl = 0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_zr, rsp_ng, rsp_id;
    logic [15:0] rsp_out;
    logic        fp_r0, fp_r1, fp_valid, fp_zr, fp_ng, fp_id;
    logic [15:0] fp_out;
`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, fp_cnt0, fp_cnt1;
`endif

    alu_arbiter #(.FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req1_x(req1_x), .req1_y(req1_y),
        .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .rsp_id(rsp_id)
`ifdef ALU_ARBITER_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    alu_arbiter #(.FAIR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(fp_r0), .req1_ready(fp_r1),
        .req0_x(req0_x), .req0_y(req0_y), .req1_x(req1_x), .req1_y(req1_y),
        .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
        .rsp_valid(fp_valid), .rsp_ready(rsp_ready),
        .rsp_out(fp_out), .rsp_zr(fp_zr), .rsp_ng(fp_ng), .rsp_id(fp_id)
`ifdef ALU_ARBITER_STATS_EN
        , .grant_cnt0(fp_cnt0), .grant_cnt1(fp_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] out;
        logic        id;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;
    int   cnt0_m = 0, cnt1_m = 0;
    logic last_m = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic p, input logic [15:0] x, input logic [15:0] y,
                         input logic [5:0] c, input logic v);
        if (p) begin
            req1_valid = v; req1_x = x; req1_y = y; req1_ctrl = c;
        end else begin
            req0_valid = v; req0_x = x; req0_y = y; req0_ctrl = c;
        end
    endtask

    task automatic issue(input logic p, input logic [15:0] x, input logic [15:0] y,
                         input logic [5:0] c, input logic [15:0] e);
        int n = 0;
        @(negedge clk);
        drive(p, x, y, c, 1'b1);
        #1;
        while (!(p ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("hs_wait", 32'(n < 20), 1);
        q.push_back('{e, p});
        if (p) cnt1_m++; else cnt0_m++;
        @(posedge clk);
        #1 drive(p, x, y, c, 1'b0);
    endtask

    task automatic rsp_take(input string tag);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait"}, 32'(n < 20), 1);
        e = q.pop_front();
        chk({tag, "_out"}, rsp_out, e.out);
        chk({tag, "_zr"}, rsp_zr, e.out == 16'h0);
        chk({tag, "_ng"}, rsp_ng, e.out[15]);
        chk({tag, "_id"}, rsp_id, e.id);
        last_m = e.id;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n, prev;
        logic pid;
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_out", rsp_out, 0);
        chk("rst_zr", rsp_zr, 0);
        chk("rst_ng", rsp_ng, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_r0", req0_ready, 0);
        chk("rst_r1", req1_ready, 0);
`ifdef ALU_ARBITER_STATS_EN
        chk("rst_cnt0", grant_cnt0, 0);
        chk("rst_cnt1", grant_cnt1, 0);
`endif
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, 16'd5, 16'd3, CTRL_XPLUSY, 16'd8);
        @(negedge clk);
        chk("lat_exec", rsp_valid, 0);
        @(negedge clk);
        chk("lat_resp", rsp_valid, 1);
        rsp_take("add");
        issue(1'b1, 16'd3, 16'd5, CTRL_XMINUSY, 16'hFFFE);
        rsp_take("sub");
        issue(1'b0, 16'h1234, 16'h5678, CTRL_ZERO, 16'h0000);
        rsp_take("zero");
        issue(1'b1, 16'h1234, 16'h5678, CTRL_NEG1, 16'hFFFF);
        rsp_take("neg1");
        issue(1'b0, 16'h00FF, 16'h0000, CTRL_NOTX, 16'hFF00);
        rsp_take("notx");

        @(negedge clk);
        drive(1'b0, 16'd10, 16'd1, CTRL_XPLUSY, 1'b1);
        drive(1'b1, 16'd10, 16'd1, CTRL_XMINUSY, 1'b1);
        rsp_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            pid = ~last_m;
            q.push_back('{pid ? 16'd9 : 16'd11, pid});
            if (pid) cnt1_m++; else cnt0_m++;
            n = 0;
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rr_wait", 32'(n < 20), 1);
            e = q.pop_front();
            chk("rr_id", rsp_id, e.id);
            chk("rr_out", rsp_out, e.out);
            chk("fp_valid", fp_valid, 1);
            chk("fp_id", fp_id, 0);
            chk("fp_out", fp_out, 16'd11);
            if (i > 0) chk("rr_period", cyc - prev, 3);
            prev = cyc;
            last_m = e.id;
            @(posedge clk);
            #1;
        end
        drive(1'b0, 16'd0, 16'd0, 6'd0, 1'b0);
        drive(1'b1, 16'd0, 16'd0, 6'd0, 1'b0);
        rsp_ready = 1'b0;

        issue(1'b0, 16'd100, 16'd23, CTRL_XPLUSY, 16'd123);
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 16'd1, 16'd1, CTRL_XPLUSY, 1'b1);
        q.push_back('{16'd2, 1'b1});
        cnt1_m++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_out", rsp_out, 16'd123);
            chk("bp_r0", req0_ready, 0);
            chk("bp_r1", req1_ready, 0);
        end
        rsp_take("bp");
        chk("bp_regrant", req1_ready, 1);
        @(posedge clk);
        #1 drive(1'b1, 16'd1, 16'd1, CTRL_XPLUSY, 1'b0);
        rsp_take("bp2");
`ifdef ALU_ARBITER_STATS_EN
        chk("cnt0", grant_cnt0, cnt0_m);
        chk("cnt1", grant_cnt1, cnt1_m);
`endif

        @(negedge clk);
        drive(1'b0, 16'd1, 16'd1, CTRL_XPLUSY, 1'b1);
        #1 chk("mid_hs", req0_ready, 1);
        @(posedge clk);
        #1 drive(1'b0, 16'd1, 16'd1, CTRL_XPLUSY, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", rsp_valid, 0);
        chk("mid_out", rsp_out, 0);
        chk("mid_id", rsp_id, 0);
        cnt0_m = 0;
        cnt1_m = 0;
        last_m = 1'b1;
`ifdef ALU_ARBITER_STATS_EN
        chk("mid_cnt0", grant_cnt0, 0);
        chk("mid_cnt1", grant_cnt1, 0);
`endif
        repeat (2) @(negedge clk);
        chk("mid_hold", rsp_valid, 0);
        rst_n = 1'b1;
        issue(1'b1, 16'd7, 16'd2, CTRL_XMINUSY, 16'd5);
        rsp_take("post");
`ifdef ALU_ARBITER_STATS_EN
        chk("post_cnt0", grant_cnt0, cnt0_m);
        chk("post_cnt1", grant_cnt1, cnt1_m);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
